// File: rtl/bus_pkg.sv
// Shared definitions for the bus front end: arbiter state encoding, read-select
// codes and the default slave address map.
package bus_pkg;

  typedef enum logic {
    M0_GRANT = 1'b0,
    M1_GRANT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    RSEL_NONE = 2'b00,
    RSEL_S0   = 2'b01,
    RSEL_S1   = 2'b10
  } rsel_t;

  // Each slave owns a 32-word region, so only the top three address bits decode.
  localparam int         REGION_W    = 3;
  localparam logic [7:0] DEF_S0_BASE = 8'h00;
  localparam logic [7:0] DEF_S1_BASE = 8'h20;

endpackage

// File: rtl/bus_arb_dec_if.sv
// Bundles the master request, slave select and read-return signals of the bus.
// The slave modport is the arbiter/decoder's view; master is the surrounding bus.
interface bus_arb_dec_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              m0_req;
  logic              m1_req;
  logic              m0_wr;
  logic              m1_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_dout;
  logic [DATA_W-1:0] m1_dout;
  logic              m0_grant;
  logic              m1_grant;
  logic              s0_sel;
  logic              s1_sel;
  logic [ADDR_W-1:0] s_addr;
  logic              s_wr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s0_dout;
  logic [DATA_W-1:0] s1_dout;
  logic [DATA_W-1:0] m_din;
  logic              dec_err;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
    input  s0_dout, s1_dout,
    output m0_grant, m1_grant, s0_sel, s1_sel, s_addr, s_wr, s_din,
    output m_din, dec_err
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
    output s0_dout, s1_dout,
    input  m0_grant, m1_grant, s0_sel, s1_sel, s_addr, s_wr, s_din,
    input  m_din, dec_err
  );

endinterface

// File: rtl/bus_addr_dec.sv
// Combinational region decoder: turns the owner's region bits and request into
// one-hot slave selects, or an unmapped flag when no slave claims the address.
module bus_addr_dec
  import bus_pkg::*;
#(
  parameter logic [REGION_W-1:0] S0_REGION = DEF_S0_BASE[7 -: REGION_W],
  parameter logic [REGION_W-1:0] S1_REGION = DEF_S1_BASE[7 -: REGION_W]
) (
  input  logic [REGION_W-1:0] region,
  input  logic                req,
  output logic                s0_sel,
  output logic                s1_sel,
  output logic                unmapped
);

  // S0 wins if both bases were ever configured to the same region.
  always_comb begin
    s0_sel   = 1'b0;
    s1_sel   = 1'b0;
    unmapped = 1'b0;
    if (req) begin
      if (region == S0_REGION) begin
        s0_sel = 1'b1;
      end else if (region == S1_REGION) begin
        s1_sel = 1'b1;
      end else begin
        unmapped = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arb_dec.sv
// Two-master arbiter and two-slave address decoder with a registered read
// return path; M1 holds the bus until it drops its request.
module bus_arb_dec
  import bus_pkg::*;
#(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] S0_BASE = DEF_S0_BASE,
  parameter logic [ADDR_W-1:0] S1_BASE = DEF_S1_BASE
) (
  input  logic            clk,
  input  logic            reset,
  bus_arb_dec_if.slave    bus
);

  localparam logic [REGION_W-1:0] S0_REGION = S0_BASE[ADDR_W-1 -: REGION_W];
  localparam logic [REGION_W-1:0] S1_REGION = S1_BASE[ADDR_W-1 -: REGION_W];

  arb_state_t        state;
  arb_state_t        stateNext;
  rsel_t             rsel;
  rsel_t             rselNext;
  logic              ownReq;
  logic              ownWr;
  logic [ADDR_W-1:0] ownAddr;
  logic [DATA_W-1:0] ownDin;
  logic              s0Sel;
  logic              s1Sel;
  logic              unmapped;
  logic              decErr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= M0_GRANT;
    end else begin
      state <= stateNext;
    end
  end

  // M0 is the default owner; M1 only takes over when M0 is idle and then keeps it.
  always_comb begin
    stateNext = state;
    case (state)
      M0_GRANT: if (!bus.m0_req && bus.m1_req) stateNext = M1_GRANT;
      M1_GRANT: if (!bus.m1_req) stateNext = M0_GRANT;
      default:  stateNext = M0_GRANT;
    endcase
  end

  always_comb begin
    ownReq  = bus.m0_req;
    ownWr   = bus.m0_wr;
    ownAddr = bus.m0_addr;
    ownDin  = bus.m0_dout;
    if (state == M1_GRANT) begin
      ownReq  = bus.m1_req;
      ownWr   = bus.m1_wr;
      ownAddr = bus.m1_addr;
      ownDin  = bus.m1_dout;
    end
  end

  bus_addr_dec #(
    .S0_REGION (S0_REGION),
    .S1_REGION (S1_REGION)
  ) u_dec (
    .region   (ownAddr[ADDR_W-1 -: REGION_W]),
    .req      (ownReq),
    .s0_sel   (s0Sel),
    .s1_sel   (s1Sel),
    .unmapped (unmapped)
  );

  // Only mapped reads remember a source; writes, idles and misses return zero.
  always_comb begin
    rselNext = RSEL_NONE;
    if (!ownWr) begin
      if (s0Sel) begin
        rselNext = RSEL_S0;
      end else if (s1Sel) begin
        rselNext = RSEL_S1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel   <= RSEL_NONE;
      decErr <= 1'b0;
    end else begin
      rsel   <= rselNext;
      decErr <= unmapped;
    end
  end

  always_comb begin
    bus.m_din = '0;
    case (rsel)
      RSEL_S0: bus.m_din = bus.s0_dout;
      RSEL_S1: bus.m_din = bus.s1_dout;
      default: bus.m_din = '0;
    endcase
  end

  assign bus.m0_grant = (state == M0_GRANT);
  assign bus.m1_grant = (state == M1_GRANT);
  assign bus.s0_sel   = s0Sel;
  assign bus.s1_sel   = s1Sel;
  assign bus.s_addr   = ownAddr;
  assign bus.s_din    = ownDin;
  assign bus.s_wr     = ownWr && (s0Sel || s1Sel);
  assign bus.dec_err  = decErr;

endmodule
